// File: rtl/rr_decode_scheduler_if.sv
// Purpose: request/grant bundle between requesters and the shared decoder scheduler.
// Latency: none; plain wiring of the signals exchanged with the scheduler.
// Backpressure: none; req is level-held by each requester until it is served.
interface rr_decode_scheduler_if;
  logic        en;
  logic [15:0] req;
  logic [3:0]  grant_idx;
  logic        grant_valid;
  logic        preempt;
  logic        busy;

  modport master (
    output en, req,
    input  grant_idx, grant_valid, preempt, busy
  );

  modport slave (
    input  en, req,
    output grant_idx, grant_valid, preempt, busy
  );
endinterface

// File: rtl/rr_decode_scheduler.sv
// Purpose: round-robin sharing of one 4-to-16 decoder among 16 requesters, with bounded tenure.
// Latency: grant is visible 1 cycle after req is sampled; 2 cycles after a release (one gap cycle).
// Backpressure: en low drops the current grant and blocks new ones; pending reqs just wait.
module rr_decode_scheduler #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_decode_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_grant_idx;
  logic [3:0]        w_grant_idx_nxt;
  logic              r_grant_valid;
  logic              w_grant_valid_nxt;
  logic              r_preempt;
  logic              w_preempt_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_cnt_nxt;
  logic [3:0]        r_last_ptr;
  logic [3:0]        w_last_ptr_nxt;

  logic              w_win_vld;
  logic [3:0]        w_win_idx;
  logic              w_others_pend;

  // Rotating priority search: start just after the last served index and wrap upward.
  always_comb begin
    logic [3:0] cand;
    w_win_vld = 1'b0;
    w_win_idx = 4'd0;
    cand      = 4'd0;
    for (int k = 1; k <= 16; k++) begin
      cand = r_last_ptr + 4'(k);
      if (!w_win_vld && bus.req[cand]) begin
        w_win_vld = 1'b1;
        w_win_idx = cand;
      end
    end
  end

  // Anyone besides the current grantee waiting; only such contention can trigger the hold limit.
  assign w_others_pend = |(bus.req & ~(16'd1 << r_grant_idx));

  // Next-state and next-output logic; every exit from GRANT passes through one GAP cycle.
  always_comb begin
    w_state_nxt       = r_state;
    w_grant_idx_nxt   = r_grant_idx;
    w_grant_valid_nxt = r_grant_valid;
    w_preempt_nxt     = 1'b0;
    w_hold_cnt_nxt    = r_hold_cnt;
    w_last_ptr_nxt    = r_last_ptr;

    case (r_state)
      S_IDLE, S_GAP: begin
        if (bus.en && w_win_vld) begin
          w_state_nxt       = S_GRANT;
          w_grant_idx_nxt   = w_win_idx;
          w_grant_valid_nxt = 1'b1;
          w_hold_cnt_nxt    = '0;
        end else begin
          w_state_nxt       = S_IDLE;
          w_grant_valid_nxt = 1'b0;
        end
      end
      S_GRANT: begin
        if (!bus.en || !bus.req[r_grant_idx]) begin
          // Disable or release: leave quietly, no preempt even if the limit was also reached.
          w_state_nxt       = S_GAP;
          w_grant_valid_nxt = 1'b0;
          w_last_ptr_nxt    = r_grant_idx;
        end else if ((r_hold_cnt == HOLD_LAST) && w_others_pend) begin
          w_state_nxt       = S_GAP;
          w_grant_valid_nxt = 1'b0;
          w_last_ptr_nxt    = r_grant_idx;
          w_preempt_nxt     = 1'b1;
        end else if (r_hold_cnt != HOLD_LAST) begin
          // Saturating count lets a lone requester keep its grant indefinitely.
          w_hold_cnt_nxt = r_hold_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt       = S_IDLE;
        w_grant_valid_nxt = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers; reset is synchronous so it lands on the next edge mid-grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_grant_idx   <= 4'd0;
      r_grant_valid <= 1'b0;
      r_preempt     <= 1'b0;
      r_busy        <= 1'b0;
      r_hold_cnt    <= '0;
      r_last_ptr    <= 4'd15;
    end else begin
      r_state       <= w_state_nxt;
      r_grant_idx   <= w_grant_idx_nxt;
      r_grant_valid <= w_grant_valid_nxt;
      r_preempt     <= w_preempt_nxt;
      r_busy        <= w_busy_nxt;
      r_hold_cnt    <= w_hold_cnt_nxt;
      r_last_ptr    <= w_last_ptr_nxt;
    end
  end

  assign bus.grant_idx   = r_grant_idx;
  assign bus.grant_valid = r_grant_valid;
  assign bus.preempt     = r_preempt;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_rr_decode_scheduler.sv
// Purpose: directed and random stimulus for rr_decode_scheduler against a tenure-based reference model.
// Latency: outputs checked 1 time unit after every rising edge.
// Backpressure: en and req driven freely by the bench.
module tb_rr_decode_scheduler;
  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  logic rst_n;

  rr_decode_scheduler_if bus ();

  rr_decode_scheduler #(
    .MAX_HOLD(MAX_HOLD),
    .HOLD_W  (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the decoder, for how many cycles, and who was served last.
  int m_owner;   // -1 when nobody holds a grant
  int m_last;
  int m_tenure;  // grant cycles completed by the current owner, counting the visible one
  bit m_gap;
  bit m_pre;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [15:0] r, input int last);
    for (int k = 1; k <= 16; k++) begin
      if (r[(last + k) % 16]) return (last + k) % 16;
    end
    return -1;
  endfunction

  task automatic model_step(input logic rs, input logic e, input logic [15:0] r);
    int w;
    if (!rs) begin
      m_owner = -1; m_last = 15; m_tenure = 0; m_gap = 0; m_pre = 0;
      return;
    end
    m_pre = 0;
    if (m_owner >= 0) begin
      if (!e || !r[m_owner]) begin
        m_last = m_owner; m_owner = -1; m_gap = 1;
      end else if (m_tenure >= MAX_HOLD && (r & ~(16'd1 << m_owner)) != 16'd0) begin
        m_last = m_owner; m_owner = -1; m_gap = 1; m_pre = 1;
      end else if (m_tenure < 100000) begin
        m_tenure++;
      end
    end else begin
      w = e ? pick(r, m_last) : -1;
      if (w >= 0) begin
        m_owner = w; m_tenure = 1;
      end
      m_gap = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(rst_n, bus.en, bus.req);
    #1;
    check("m_valid", int'(bus.grant_valid), int'(m_owner >= 0));
    check("m_busy", int'(bus.busy), int'((m_owner >= 0) || m_gap));
    check("m_preempt", int'(bus.preempt), int'(m_pre));
    if (m_owner >= 0) check("m_idx", int'(bus.grant_idx), m_owner);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.en  = 1'b0;
    bus.req = 16'h0000;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int       order[$];
    int       exp_order[5];
    int       gcnt;
    int       zeros;
    bit       seen;
    int       n3;
    bit       done;
    int       bad;
    logic [15:0] rmask;

    exp_order = '{0, 5, 10, 15, 0};

    // 1: single requester, release, return to idle
    do_reset();
    check("rst_valid", int'(bus.grant_valid), 0);
    check("rst_idx", int'(bus.grant_idx), 0);
    check("rst_preempt", int'(bus.preempt), 0);
    check("rst_busy", int'(bus.busy), 0);
    bus.en  = 1'b1;
    bus.req = 16'h0001;
    tick();
    check("t1_valid", int'(bus.grant_valid), 1);
    check("t1_idx", int'(bus.grant_idx), 0);
    bus.req = 16'h0000;
    tick();
    check("t1_drop_valid", int'(bus.grant_valid), 0);
    check("t1_gap_busy", int'(bus.busy), 1);
    tick();
    check("t1_idle_busy", int'(bus.busy), 0);

    // 2: round-robin order with release after 2 cycles and re-assert in the gap
    do_reset();
    bus.en  = 1'b1;
    bus.req = 16'h8421;
    gcnt = 0; zeros = 0; seen = 0;
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      tick();
      if (bus.grant_valid) begin
        gcnt++;
        if (gcnt == 1) begin
          order.push_back(int'(bus.grant_idx));
          if (seen) check("t2_gap_len", zeros, 1);
          seen = 1;
        end
        if (gcnt == 2) bus.req = 16'h8421 & ~(16'd1 << bus.grant_idx);
        zeros = 0;
      end else begin
        gcnt = 0;
        zeros++;
        bus.req = 16'h8421;
      end
    end
    check("t2_count", order.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < order.size()) check($sformatf("t2_order%0d", i), order[i], exp_order[i]);
    end

    // 3: hold limit preempts requester 3 in favour of 7
    do_reset();
    bus.en  = 1'b1;
    bus.req = 16'h0008;
    n3 = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      if (bus.grant_valid && bus.grant_idx == 4'd3) begin
        n3++;
        if (n3 == 2) bus.req = 16'h0088;
      end else if (!bus.grant_valid && n3 > 0) begin
        done = 1;
      end
    end
    check("t3_done", int'(done), 1);
    check("t3_hold_cycles", n3, MAX_HOLD);
    check("t3_preempt", int'(bus.preempt), 1);
    tick();
    check("t3_preempt_once", int'(bus.preempt), 0);
    check("t3_next_valid", int'(bus.grant_valid), 1);
    check("t3_next_idx", int'(bus.grant_idx), 7);
    bus.req = 16'h0008;
    tick();
    check("t3_rel_preempt", int'(bus.preempt), 0);
    check("t3_rel_valid", int'(bus.grant_valid), 0);
    tick();
    check("t3_regrant_idx", int'(bus.grant_idx), 3);
    check("t3_regrant_valid", int'(bus.grant_valid), 1);

    // 4: lone requester is never preempted
    do_reset();
    bus.en  = 1'b1;
    bus.req = 16'h1000;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (bus.preempt || !bus.busy || !bus.grant_valid || bus.grant_idx != 4'd12) bad++;
    end
    check("t4_lone_violations", bad, 0);

    // 5: wrap-around from 15 to 0, then en drop mid-grant
    do_reset();
    bus.en  = 1'b1;
    bus.req = 16'h4000;
    tick();
    check("t5_idx14", int'(bus.grant_idx), 14);
    bus.req = 16'h0000;
    tick();
    tick();
    check("t5_idle", int'(bus.busy), 0);
    bus.req = 16'h8001;
    tick();
    check("t5_first15", int'(bus.grant_idx), 15);
    tick();
    bus.req = 16'h0001;
    tick();
    tick();
    check("t5_then0", int'(bus.grant_idx), 0);
    check("t5_then0_valid", int'(bus.grant_valid), 1);
    bus.req = 16'h8000;
    tick();
    tick();
    check("t5_again15", int'(bus.grant_idx), 15);
    tick();
    bus.en = 1'b0;
    tick();
    check("t5_en_drop", int'(bus.grant_valid), 0);
    tick();
    check("t5_en_idle", int'(bus.busy), 0);
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.grant_valid || bus.busy) bad++;
    end
    check("t5_no_grant_en0", bad, 0);

    // 6: synchronous reset mid-grant
    do_reset();
    bus.en  = 1'b1;
    bus.req = 16'hFFFF;
    tick();
    bus.req = 16'hFFFE;
    tick();
    tick();
    check("t6_pre_idx", int'(bus.grant_idx), 1);
    bus.req = 16'hFFFF;
    tick();
    rst_n = 1'b0;
    tick();
    check("t6_rst_valid", int'(bus.grant_valid), 0);
    check("t6_rst_idx", int'(bus.grant_idx), 0);
    check("t6_rst_preempt", int'(bus.preempt), 0);
    check("t6_rst_busy", int'(bus.busy), 0);
    rst_n = 1'b1;
    tick();
    check("t6_first_valid", int'(bus.grant_valid), 1);
    check("t6_first_idx", int'(bus.grant_idx), 0);

    // 7: random traffic against the model
    do_reset();
    bus.en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      rmask   = 16'($urandom & $urandom & $urandom & $urandom & $urandom);
      bus.req = bus.req ^ rmask;
      bus.en  = ($urandom_range(0, 24) != 0);
      rst_n   = ($urandom_range(0, 399) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_decode_scheduler.md
Name: rr_decode_scheduler

Overview:
- Round-robin arbiter that shares one 4-to-16 one-hot decoder (and the resource it enables) among 16 requesters.
- Grants one requester at a time as a registered 4-bit index plus valid. The index drives the decoder input; valid gates the decoded enables.
- Bounds grant tenure with a hold limit.
- Inserts a one-cycle break-before-make gap between consecutive grants.

Parameters:
- MAX_HOLD, 8: max cycles a grant is held while another requester is pending. Legal range 2..255.
- HOLD_W, 8: width of the hold counter. Must satisfy MAX_HOLD-1 < 2^HOLD_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  scheduler enable. When low, no new grant is issued and a current grant is dropped.
- req  input  16  request vector; bit i = requester i. Level-sensitive, held until served.
- grant_idx  output  4  index of the granted requester; drives the decoder input.
- grant_valid  output  1  high while grant_idx is a live grant.
- preempt  output  1  one-cycle pulse when a grant is revoked by the hold limit.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous, active-low, sampled on the rising edge of clk.
- Reset values: state=IDLE, grant_idx=0, grant_valid=0, preempt=0, busy=0, hold_cnt=0, last_ptr=15 (so the first search starts at 0).
- Reset mid-grant: takes effect at the next edge with no gap cycle; grant_valid falls in that cycle.
- All outputs are registered; there is no combinational path from req to outputs.
- States: IDLE, GRANT, GAP.
- Arbitration function:
  - Scan req starting at (last_ptr+1) mod 16 and wrap upward; the first set bit wins.
  - The requester just served is therefore lowest priority; wrap-around from 15 to 0 is required.
- IDLE:
  - If en=1 and req!=0 at an edge: go to GRANT, grant_idx=winner, grant_valid=1, hold_cnt=0.
  - Latency: grant is visible the cycle after req is first sampled.
  - Otherwise remain in IDLE.
- GRANT, evaluated each edge in priority order:
  1. en=0 → GAP.
  2. req[grant_idx]=0 (release) → GAP.
  3. hold_cnt=MAX_HOLD-1 and (req with bit grant_idx masked)!=0 → GAP, with preempt=1 for exactly the first GAP cycle.
  4. Otherwise stay; hold_cnt increments and saturates at MAX_HOLD-1.
  - On any exit to GAP: grant_valid=0, last_ptr=grant_idx.
  - grant_idx holds its value through GAP; it is don't-care while grant_valid=0.
- Lone requester: never preempted. Its hold_cnt saturates, and the grant persists indefinitely while its req stays high.
- GAP: lasts exactly one cycle with grant_valid=0. At its closing edge, arbitrate as in IDLE:
  - winner present → GRANT (next grant is visible 2 cycles after the release was sampled);
  - no winner, or en=0 → IDLE.
- Preempted requester: its req is still high, so it re-enters arbitration at lowest priority.
- Simultaneous events:
  - Release and new requests on the same edge: treated as a release; no preempt.
  - Release and the hold limit on the same edge: release wins; preempt=0.
  - Requester re-asserting in GAP: it competes normally but ranks last.
- busy=1 in GRANT and GAP; busy=0 in IDLE.
- grant_valid never stays high across a change of grant_idx. Grants never overlap and never switch back-to-back.

Test Plan:
- Reset then req=16'h0001, en=1 → grant_valid=1, grant_idx=0 one cycle later; drop req → grant_valid=0 next cycle; IDLE two cycles after the drop.
- After reset, req=16'h8421 held constant, each grantee releasing after 2 cycles and re-asserting during the gap → grant order 0,5,10,15,0, each separated by exactly one grant_valid=0 cycle.
- MAX_HOLD=8, req[3] held, req[7] asserted at grant cycle 2 → preempt pulses once after 8 grant cycles, then 1 gap cycle, then grant_idx=7; idx 3 is regranted after 7 releases.
- Lone req[12] held for 50 cycles → continuous grant, preempt never asserted, busy=1 throughout.
- Wrap-around: last_ptr=14, req=16'h8001 → grant 15 first, then 0. en deasserted mid-grant of 15 → grant_valid=0 next edge, then IDLE with no new grant while en=0.
- rst_n=0 for one edge during GRANT with req=16'hFFFF → all outputs at reset values next cycle. After rst_n=1, the first grant is index 0.
